// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared header layout, limits and framer state encoding
package router_pkg;

  // Header byte layout: {2'b00, len[3:0], dest[1:0]}
  localparam int DEST_LSB     = 0;
  localparam int DEST_W       = 2;
  localparam int LEN_LSB      = 2;
  localparam int LEN_W        = 4;
  localparam int MAX_LEN      = 15;
  localparam int NUM_CHANNELS = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_HDR,
    ST_PAY,
    ST_PAR,
    ST_GAP
  } state_t;

  function automatic logic [7:0] make_header(input logic [DEST_W-1:0] dest,
                                             input logic [LEN_W-1:0]  len);
    logic [7:0] h;
    h = '0;
    h[DEST_LSB +: DEST_W] = dest;
    h[LEN_LSB +: LEN_W]   = len;
    return h;
  endfunction

  // A request is legal when it targets an existing channel and carries payload
  function automatic logic req_legal(input logic [DEST_W-1:0] dest,
                                     input logic [LEN_W-1:0]  len);
    return (int'(dest) < NUM_CHANNELS) && (int'(len) >= 1) && (int'(len) <= MAX_LEN);
  endfunction

endpackage

// File: rtl/pkt_fifo.sv
// rtl/pkt_fifo.sv - first-word-fall-through byte staging FIFO
module pkt_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_en,
  input  logic [WIDTH-1:0]               wr_data,
  input  logic                           rd_en,
  output logic [WIDTH-1:0]               rd_data,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  // Writes to a full FIFO are dropped so stored data is never overwritten
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;
  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign rd_data = mem[rd_ptr];

  // Storage array; contents need no reset since level gates visibility
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally at the power-of-two depth; level tracks occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/pkt_framer.sv
// rtl/pkt_framer.sv - frames staged payload bytes into header/payload/parity packets
module pkt_framer
  import router_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              wr_en,
  input  logic [7:0]                        wr_data,
  output logic                              full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   level,
  input  logic                              start,
  input  logic [1:0]                        dest,
  input  logic [3:0]                        len,
  output logic                              ready,
  output logic                              err,
  input  logic                              dest_busy,
  output logic                              pkt_v,
  output logic [7:0]                        dout,
  output logic                              done
);

  localparam int LW = $clog2(FIFO_DEPTH+1);

  state_t     state;
  state_t     state_nxt;
  logic [1:0] dest_q;
  logic [3:0] len_q;
  logic [3:0] cnt_q;
  logic [7:0] acc_q;
  logic       err_q;
  logic       pop;
  logic [7:0] fifo_head;
  logic       fifo_empty;
  logic [7:0] header;
  logic       legal;

  assign legal  = req_legal(dest, len);
  assign header = make_header(dest_q, len_q);
  assign err    = err_q;

  pkt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .full    (full),
    .empty   (fifo_empty),
    .level   (level)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Request latch, error pulse, payload countdown and running parity
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dest_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
      acc_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= ready && start && !legal;
      if (ready && start && legal) begin
        dest_q <= dest;
        len_q  <= len;
      end
      case (state)
        ST_HDR: begin
          acc_q <= header;
          cnt_q <= len_q;
        end
        ST_PAY: begin
          acc_q <= acc_q ^ fifo_head;
          cnt_q <= cnt_q - 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Next-state and packet stream outputs; the header only launches once the
  // whole payload is staged, so PAY can never pop an empty FIFO
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    pkt_v     = 1'b0;
    dout      = 8'h00;
    done      = 1'b0;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        ready = 1'b1;
        if (start && legal) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if ((level >= LW'(len_q)) && !dest_busy) state_nxt = ST_HDR;
      end
      ST_HDR: begin
        pkt_v     = 1'b1;
        dout      = header;
        state_nxt = ST_PAY;
      end
      ST_PAY: begin
        pkt_v = 1'b1;
        dout  = fifo_head;
        pop   = !fifo_empty;
        if (cnt_q == 4'd1) state_nxt = ST_PAR;
      end
      ST_PAR: begin
        pkt_v     = 1'b1;
        dout      = acc_q;
        done      = 1'b1;
        state_nxt = ST_GAP;
      end
      ST_GAP: begin
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pkt_framer.sv
// tb/tb_pkt_framer.sv - scoreboard bench for pkt_framer
module tb_pkt_framer;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic [4:0] level;
  logic       start;
  logic [1:0] dest;
  logic [3:0] len;
  logic       ready;
  logic       err;
  logic       dest_busy;
  logic       pkt_v;
  logic [7:0] dout;
  logic       done;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } sb_t;

  sb_t        sb[$];
  logic [7:0] model[$];
  int         n_checks = 0;
  int         n_pass   = 0;

  pkt_framer #(.FIFO_DEPTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .level     (level),
    .start     (start),
    .dest      (dest),
    .len       (len),
    .ready     (ready),
    .err       (err),
    .dest_busy (dest_busy),
    .pkt_v     (pkt_v),
    .dout      (dout),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    if (model.size() < 16) model.push_back(b);
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic req(input logic [1:0] d, input logic [3:0] l);
    start = 1'b1;
    dest  = d;
    len   = l;
    cyc();
    start = 1'b0;
  endtask

  task automatic expect_packet(input logic [1:0] d, input logic [3:0] l);
    logic [7:0] acc;
    logic [7:0] b;
    acc = {2'b00, l, d};
    sb.push_back('{data: acc, last: 1'b0});
    for (int i = 0; i < int'(l); i++) begin
      b = model.pop_front();
      acc ^= b;
      sb.push_back('{data: b, last: 1'b0});
    end
    sb.push_back('{data: acc, last: 1'b1});
  endtask

  task automatic wait_done(input int max);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      cyc();
      if (done) seen = 1'b1;
    end
    check_eq("done_seen", 32'(seen), 32'd1);
    cyc();
    check_eq("gap_pkt_v", 32'(pkt_v), 32'd0);
    check_eq("gap_ready", 32'(ready), 32'd0);
    cyc();
    check_eq("idle_ready", 32'(ready), 32'd1);
    check_eq("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  // Output monitor: every packet byte is popped from the scoreboard
  always @(negedge clk) begin
    sb_t e;
    if (pkt_v) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_pkt_v", 32'(pkt_v), 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq("dout", 32'(dout), 32'(e.data));
        check_eq("done_flag", 32'(done), 32'(e.last));
      end
    end else begin
      check_eq("idle_dout", 32'(dout), 32'd0);
      check_eq("idle_done", 32'(done), 32'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] b0, b1, b2;
    rst_n     = 1'b0;
    wr_en     = 1'b0;
    wr_data   = 8'h00;
    start     = 1'b0;
    dest      = 2'd0;
    len       = 4'd0;
    dest_busy = 1'b0;

    // Reset
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();
    check_eq("rst_ready", 32'(ready), 32'd1);
    check_eq("rst_pkt_v", 32'(pkt_v), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_level", 32'(level), 32'd0);
    check_eq("rst_full", 32'(full), 32'd0);

    // Basic packet
    push(8'h11); push(8'h22); push(8'h33);
    req(2'd1, 4'd3);
    expect_packet(2'd1, 4'd3);
    wait_done(20);

    // Illegal requests
    req(2'd3, 4'd2);
    check_eq("err_dest3", 32'(err), 32'd1);
    check_eq("err_ready", 32'(ready), 32'd1);
    cyc();
    check_eq("err_clear", 32'(err), 32'd0);
    req(2'd0, 4'd0);
    check_eq("err_len0", 32'(err), 32'd1);
    cyc();
    check_eq("err_clear2", 32'(err), 32'd0);
    check_eq("err_ready2", 32'(ready), 32'd1);

    // Wait for payload to arrive
    push(8'h5A); push(8'hC3);
    req(2'd2, 4'd4);
    repeat (3) cyc();
    check_eq("wait_ready", 32'(ready), 32'd0);
    check_eq("wait_pkt_v", 32'(pkt_v), 32'd0);
    push(8'h0F); push(8'hF0);
    expect_packet(2'd2, 4'd4);
    check_eq("wait_no_hdr_yet", 32'(pkt_v), 32'd0);
    cyc();
    check_eq("wait_hdr", 32'(dout), 32'h12);
    wait_done(20);

    // Downstream busy holds the header; start while busy is ignored
    dest_busy = 1'b1;
    push(8'h81); push(8'h82); push(8'h83);
    req(2'd0, 4'd3);
    req(2'd3, 4'd0);
    check_eq("busy_start_no_err", 32'(err), 32'd0);
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (pkt_v) check_eq("busy_pkt_v", 32'(pkt_v), 32'd0);
    end
    check_eq("busy_level", 32'(level), 32'd3);
    expect_packet(2'd0, 4'd3);
    dest_busy = 1'b0;
    cyc();
    check_eq("busy_release_hdr", 32'(dout), 32'h0C);
    dest_busy = 1'b1;
    wait_done(20);
    dest_busy = 1'b0;

    // Write and pop in the same cycle
    push(8'h91); push(8'h92); push(8'h93);
    req(2'd1, 4'd3);
    expect_packet(2'd1, 4'd3);
    cyc();
    push(8'hA1); push(8'hA2);
    wait_done(20);
    check_eq("concurrent_level", 32'(level), 32'd2);
    req(2'd2, 4'd2);
    expect_packet(2'd2, 4'd2);
    wait_done(20);

    // Overflow and wrap
    for (int i = 0; i < 16; i++) push(8'h40 + 8'(i));
    check_eq("full_at_16", 32'(full), 32'd1);
    check_eq("level_16", 32'(level), 32'd16);
    push(8'hEE);
    check_eq("full_drop_level", 32'(level), 32'd16);
    req(2'd1, 4'd15);
    expect_packet(2'd1, 4'd15);
    wait_done(40);
    check_eq("level_after_15", 32'(level), 32'd1);
    check_eq("full_after_15", 32'(full), 32'd0);
    req(2'd0, 4'd1);
    expect_packet(2'd0, 4'd1);
    wait_done(20);
    check_eq("level_drained", 32'(level), 32'd0);

    // Reset mid-payload
    for (int i = 0; i < 8; i++) push(8'hB0 + 8'(i));
    b0 = model[0];
    b1 = model[1];
    b2 = model[2];
    sb.push_back('{data: 8'h21, last: 1'b0});
    sb.push_back('{data: b0, last: 1'b0});
    sb.push_back('{data: b1, last: 1'b0});
    sb.push_back('{data: b2, last: 1'b0});
    req(2'd1, 4'd8);
    cyc();
    cyc();
    cyc();
    cyc();
    check_eq("pre_rst_pay", 32'(pkt_v), 32'd1);
    rst_n = 1'b0;
    cyc();
    check_eq("rst_trunc_pkt_v", 32'(pkt_v), 32'd0);
    check_eq("rst_trunc_level", 32'(level), 32'd0);
    check_eq("rst_trunc_done", 32'(done), 32'd0);
    check_eq("rst_trunc_full", 32'(full), 32'd0);
    rst_n = 1'b1;
    model.delete();
    cyc();
    check_eq("rst_release_ready", 32'(ready), 32'd1);
    check_eq("rst_release_level", 32'(level), 32'd0);
    repeat (3) cyc();
    check_eq("rst_sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pkt_framer.md
PKT_FRAMER -- requirements
Module: pkt_framer

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, payload staging FIFO depth in bytes (power of two, >= 15).
REQ-002 clk  in  1  clock; all logic on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 wr_en  in  1  push wr_data into payload FIFO.
REQ-005 wr_data  in  8  payload byte.
REQ-006 full  out  1  FIFO holds FIFO_DEPTH bytes.
REQ-007 level  out  5  FIFO occupancy, 0..FIFO_DEPTH.
REQ-008 start  in  1  packet request, sampled only when ready=1.
REQ-009 dest  in  2  destination channel; 0..2 legal, 3 illegal.
REQ-010 len  in  4  payload length; 1..15 legal, 0 illegal.
REQ-011 ready  out  1  framer idle and accepting start.
REQ-012 err  out  1  one-cycle pulse on rejected request.
REQ-013 dest_busy  in  1  downstream router busy; gates header launch only.
REQ-014 pkt_v  out  1  byte on dout is part of a packet.
REQ-015 dout  out  8  packet byte stream: header, payload, parity.
REQ-016 done  out  1  one-cycle pulse coincident with parity byte.

Function
REQ-017 FSM states IDLE, WAIT, HDR, PAY, PAR, GAP; ready=1 only in IDLE.
REQ-018 IDLE, start=1, legal dest and len: latch dest/len, go WAIT next cycle.
REQ-019 IDLE, start=1, dest=3 or len=0: err=1 for exactly the next cycle, stay IDLE, nothing latched.
REQ-020 WAIT -> HDR when level >= latched len and dest_busy=0; otherwise remain in WAIT indefinitely.
REQ-021 Header byte = {2'b00, len[3:0], dest[1:0]}; driven in HDR; parity accumulator loaded with header.
REQ-022 PAY lasts exactly len cycles; each cycle dout = FIFO head, pop one byte, accumulator ^= byte.
REQ-023 PAR lasts one cycle: dout = accumulator (XOR of header and all payload bytes), done=1.
REQ-024 GAP lasts one cycle with pkt_v=0, then IDLE; minimum packet spacing one idle cycle.
REQ-025 pkt_v=1 exactly in HDR, PAY, PAR; dout=8'h00 whenever pkt_v=0.
REQ-026 Earliest header two cycles after start accepted; packet occupies len+2 consecutive pkt_v cycles.
REQ-027 dest_busy changes after HDR entered have no effect on the packet in flight.
REQ-028 FIFO write while full ignored and no data lost; write and pop in same cycle both take effect, level unchanged.
REQ-029 Pop on empty FIFO cannot occur (guaranteed by REQ-020); level arithmetic never wraps.
REQ-030 FIFO pointers wrap modulo FIFO_DEPTH; bytes leave in write order across wrap.
REQ-031 start while ready=0 ignored with no err.

Reset
REQ-032 rst_n=0 at an edge: state IDLE, FIFO emptied (level=0, full=0), pointers 0, accumulator 0.
REQ-033 Outputs in reset: ready=1 after release, pkt_v=0, dout=0, err=0, done=0.
REQ-034 Reset mid-packet truncates immediately; no parity byte, no done pulse.

Structure
REQ-035 Shared package router_pkg holds header field positions (DEST [1:0], LEN [5:2]), MAX_LEN=15, channel count 3, FSM state enumeration.
REQ-036 Payload FIFO is one sub-module, pkt_fifo (first-word-fall-through, parameterised depth/width); no other sub-modules.

Verification
REQ-037 Push 0x11,0x22,0x33; start dest=1 len=3 -> pkt_v stream 0x0D,0x11,0x22,0x33,0x0D, done on last, then one pkt_v=0 cycle.
REQ-038 start dest=3 len=2, then dest=0 len=0 -> err pulse each, ready stays 1, pkt_v never asserted.
REQ-039 Push 2 bytes, start dest=2 len=4 -> WAIT; push 2 more -> header 0x12 appears two cycles after the 4th push.
REQ-040 dest_busy=1 held 10 cycles with enough data -> no header; deassert -> header next cycle after WAIT sees 0.
REQ-041 Push 17 bytes -> full=1 after 16, 17th dropped, level=16; pop 15 via packet len=15 -> level=1, remaining byte is 16th written.
REQ-042 Assert rst_n=0 during PAY of a len=8 packet -> pkt_v=0 next cycle, level=0, no done, ready=1 after release.
